alu_scheduler: RTL and testbench
================================

// Module: alu_scheduler
// PURPOSE
//  Shares the single combinational ALU between NUM_REQ requesters (decode, address gen, ...).
//  Round-robin arbitration, operand capture, one ALU issue per accepted request, and a
//  registered result and flags response. Owns the architectural flags register (C, Z, N).
// PARAMETERS
//  NUM_REQ  2   number of requesters (2..4)
//  WIDTH    16  operand/result width
// PORTS
//  clk          in   1              clock; all state on rising edge
//  rst          in   1              reset, asynchronous, active-high
//  req_valid    in   NUM_REQ        per-requester request
//  req_ready    out  NUM_REQ        one-hot grant; accept when valid&ready
//  req_op       in   3*NUM_REQ      op code per requester (slice i = [3i+2:3i])
//  req_a        in   WIDTH*NUM_REQ  operand 1 per requester
//  req_b        in   WIDTH*NUM_REQ  operand 2 per requester
//  rsp_valid    out  1              response valid; held until rsp_ready
//  rsp_ready    in   1              response consumer ready
//  rsp_id       out  $clog2(NUM_REQ) index of the owning requester
//  rsp_result   out  WIDTH          captured ALU result
//  rsp_flags    out  3              flags after this op: [0]=C [1]=Z [2]=N
//  alu_op       out  3              to ALU operation
//  alu_a        out  WIDTH          to ALU operand1
//  alu_b        out  WIDTH          to ALU operand2
//  alu_result   in   WIDTH          from ALU result (combinational)
//  alu_cout     in   1              from ALU carry (flags_out[0])
//  flags_q      out  3              current flags register
// BEHAVIOUR
//  Reset (async): state IDLE, rr pointer 0, req_ready 0, rsp_* 0, flags_q 0, alu_op 3'b111,
//   alu_a/alu_b 0. Reset mid-operation drops the op; no response is ever produced for it.
//  Op codes: 000 add, 001 set C, 010 sub, 011 and, 100 not, 101 pass a, 110 pass b, 111 none.
//  FSM IDLE -> EXEC -> RESP:
//   IDLE: any req_valid -> grant winner (req_ready one-hot, combinational, same cycle),
//         capture op/a/b/id, go EXEC. Winner = first valid at or after rr pointer, wrapping.
//         rr pointer <- winner+1 (mod NUM_REQ) on acceptance only.
//   EXEC: alu_op/a/b driven from captured regs for exactly this cycle; at edge capture
//         alu_result into rsp_result, update flags_q, set rsp_valid, go RESP.
//   RESP: rsp_valid held, rsp_* stable until rsp_ready. On rsp_valid&rsp_ready: if any
//         req_valid, grant in same cycle and go EXEC (back-to-back); else go IDLE.
//  req_ready is 0 in EXEC and in RESP without rsp_ready. Latency: accept cycle N ->
//   rsp_valid at N+2. Peak throughput 1 op / 2 cycles.
//  Outside EXEC alu_op = 3'b111 and alu_a/alu_b = 0.
//  Flags: C <- alu_cout on 000; C <- 1 on 001; C unchanged otherwise.
//   Op 001: rsp_result = 0. Op 111: rsp_result = alu_result, no flag change.
//   rsp_flags = flags_q value after the update.
//  Widths: add carry is bit WIDTH of a+b; sub wraps modulo 2^WIDTH, C untouched.
//  Request withdrawn (valid dropped before grant) is legal; no state change.
// CONFIGURATION
//  ALU_SCHED_ZN_FLAGS_EN defined: Z <- (alu_result==0), N <- alu_result[WIDTH-1] on ops
//   000,010,011,100,101,110; unchanged on 001,111.
//  Not defined: Z and N bits of flags_q/rsp_flags tie to 0; only C is maintained.
// STRUCTURE
//  Package alu_sched_pkg: op code localparams, flag bit indices (FLAG_C/Z/N), FSM state
//   encoding (IDLE/EXEC/RESP).
//  Sub-module rr_arbiter: NUM_REQ-wide round-robin grant from valid vector + pointer,
//   pointer update on accept. Flags and FSM stay in alu_scheduler.
// TESTING
//  1 add: req0 op 000 a=16'hFFFF b=16'h0001 -> accept cycle N, rsp_valid N+2,
//    result 16'h0000, rsp_id 0, C=1 (Z=1 with _EN).
//  2 contention: req0 and req1 valid every cycle, rsp_ready=1 -> grants alternate
//    0,1,0,1 starting at 0 after reset; one response every 2 cycles.
//  3 backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, no ALU issue
//    (alu_op=111); release -> next pending request granted same cycle.
//  4 flags hold: op 001 -> C=1, result 0; then op 011 a=16'h00F0 b=16'h0F00 -> result 0,
//    C stays 1; with _EN Z=1,N=0; without _EN Z=N=0.
//  5 reset in EXEC: assert rst mid-cycle -> all outputs to reset values immediately,
//    no rsp_valid after release; next request granted to requester 0.
//  6 sub wrap: a=16'h0000 b=16'h0001 op 010 -> result 16'hFFFF, C unchanged, N=1 with _EN.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: op codes, flag bit positions, FSM states.
// Optional Z/N flag tracking is controlled by ALU_SCHED_ZN_FLAGS_EN in alu_scheduler.
package alu_sched_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SETC  = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_NOT   = 3'b100;
  localparam logic [2:0] OP_PASSA = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_NONE  = 3'b111;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Z/N follow the result for every real ALU op; set-carry and no-op leave them alone
  function automatic logic op_updates_zn(input logic [2:0] op);
    return !((op == OP_SETC) || (op == OP_NONE));
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request, response and ALU-side signals of the scheduler; slave = scheduler, master = environment.
// Purely a bundle: no logic, no latency, handshakes are valid/ready as seen on the members.
interface alu_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic [2:0]               rsp_flags;

  logic [2:0]               alu_op;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [WIDTH-1:0]         alu_result;
  logic                     alu_cout;

  logic [2:0]               flags_q;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_cout,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, alu_op, alu_a, alu_b, flags_q
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_cout,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, alu_op, alu_a, alu_b, flags_q
  );

endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// Round-robin grant: first valid at or after the pointer, wrapping; zero-cycle combinational grant.
// Grant only while i_en is high; pointer advances past the winner only on an accepted grant.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_valid,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_accept
);

  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_cand;
  logic          w_found;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_idx;

  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(N)) w_cand = w_cand - (IW+1)'(N);
      if (!w_found && i_valid[w_cand[IW-1:0]]) begin
        w_found                  = 1'b1;
        w_grant[w_cand[IW-1:0]]  = 1'b1;
        w_idx                    = w_cand[IW-1:0];
      end
    end
  end

  assign o_accept = i_en & w_found;
  assign o_grant  = i_en ? w_grant : '0;
  assign o_idx    = w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_accept) begin
      r_ptr <= (w_idx == IW'(N-1)) ? '0 : w_idx + IW'(1);
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU among NUM_REQ requesters; accept N -> rsp_valid N+2, 1 op / 2 cycles.
// Response held until rsp_ready; no grant while busy. ALU_SCHED_ZN_FLAGS_EN adds Z/N flag tracking.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16
) (
  input logic              clk,
  input logic              rst,
  alu_scheduler_if.slave   bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;

  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [ID_W-1:0]  r_id;

  logic [2:0]       r_flags;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic [2:0]       r_rsp_flags;
  logic [ID_W-1:0]  r_rsp_id;

  logic             w_grant_en;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_idx;
  logic             w_accept;
  logic [2:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_result;
  logic [2:0]       w_flags_nxt;

  // Grants are only offered when the pipeline can take the op next cycle
  assign w_grant_en = !rst && ((r_state == IDLE) || ((r_state == RESP) && bus.rsp_ready));

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (bus.req_valid),
    .i_en     (w_grant_en),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_accept (w_accept)
  );

  assign bus.req_ready = w_grant;

  always_comb begin
    w_sel_op = OP_NONE;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_op = bus.req_op[3*i +: 3];
        w_sel_a  = bus.req_a[WIDTH*i +: WIDTH];
        w_sel_b  = bus.req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_state_nxt = w_accept ? EXEC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= OP_NONE;
      r_a  <= '0;
      r_b  <= '0;
      r_id <= '0;
    end else if (w_accept) begin
      r_op <= w_sel_op;
      r_a  <= w_sel_a;
      r_b  <= w_sel_b;
      r_id <= w_idx;
    end
  end

  always_comb begin
    bus.alu_op = OP_NONE;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    if (r_state == EXEC) begin
      bus.alu_op = r_op;
      bus.alu_a  = r_a;
      bus.alu_b  = r_b;
    end
  end

  assign w_result = (r_op == OP_SETC) ? '0 : bus.alu_result;

  always_comb begin
    w_flags_nxt = r_flags;
    case (r_op)
      OP_ADD:  w_flags_nxt[FLAG_C] = bus.alu_cout;
      OP_SETC: w_flags_nxt[FLAG_C] = 1'b1;
      default: w_flags_nxt[FLAG_C] = r_flags[FLAG_C];
    endcase
`ifdef ALU_SCHED_ZN_FLAGS_EN
    if (op_updates_zn(r_op)) begin
      w_flags_nxt[FLAG_Z] = (bus.alu_result == '0);
      w_flags_nxt[FLAG_N] = bus.alu_result[WIDTH-1];
    end
`else
    w_flags_nxt[FLAG_Z] = 1'b0;
    w_flags_nxt[FLAG_N] = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_id     <= '0;
    end else if (r_state == EXEC) begin
      r_flags      <= w_flags_nxt;
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= w_result;
      r_rsp_flags  <= w_flags_nxt;
      r_rsp_id     <= r_id;
    end else if ((r_state == RESP) && bus.rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_flags  = r_rsp_flags;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.flags_q    = r_flags;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: op table on requester 0, contention, backpressure and reset-in-EXEC
// sequences, with a queue scoreboard checking every response against an independent flag model.
module tb_alu_scheduler;
  import alu_sched_pkg::*;

  localparam int NR = 2;
  localparam int W  = 16;
`ifdef ALU_SCHED_ZN_FLAGS_EN
  localparam logic [2:0] FMASK = 3'b111;
`else
  localparam logic [2:0] FMASK = 3'b001;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

  alu_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment ALU; non-add ops report carry 1 so any illegal C update shows up
  logic [W:0] alu_s;
  always_comb begin
    alu_s = '0;
    case (bus.alu_op)
      OP_ADD:   alu_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      OP_SETC:  alu_s = {1'b1, 16'hA5A5};
      OP_SUB:   alu_s = {1'b1, bus.alu_a - bus.alu_b};
      OP_AND:   alu_s = {1'b1, bus.alu_a & bus.alu_b};
      OP_NOT:   alu_s = {1'b1, ~bus.alu_a};
      OP_PASSA: alu_s = {1'b1, bus.alu_a};
      OP_PASSB: alu_s = {1'b1, bus.alu_b};
      default:  alu_s = {1'b0, bus.alu_a ^ bus.alu_b};
    endcase
  end
  assign bus.alu_result = alu_s[W-1:0];
  assign bus.alu_cout   = alu_s[W];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         id;
    logic [W-1:0] res;
    logic [2:0] flg;
    int         cyc;
  } sb_t;

  sb_t        sbq[$];
  int         grant_log[$];
  int         rsp_cyc[$];
  logic [2:0] m_flags;
  bit         prev_vld;

  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r);
    logic [W:0] s;
    r = '0;
    case (op)
      OP_ADD:   begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; m_flags[0] = s[W]; end
      OP_SETC:  begin r = '0; m_flags[0] = 1'b1; end
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_NOT:   r = ~a;
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      default:  r = a ^ b;
    endcase
`ifdef ALU_SCHED_ZN_FLAGS_EN
    if (op != OP_SETC && op != OP_NONE) begin
      m_flags[1] = (r == '0);
      m_flags[2] = r[W-1];
    end
`endif
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      m_flags  = '0;
      prev_vld = 1'b0;
    end else begin
      if (bus.rsp_valid && !prev_vld) begin
        if (sbq.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("rsp_latency", cyc, sbq[0].cyc + 2);
      end
      if (bus.rsp_valid && bus.rsp_ready && sbq.size() != 0) begin
        sb_t e;
        e = sbq.pop_front();
        chk("sb_id", 32'(bus.rsp_id), e.id);
        chk("sb_result", 32'(bus.rsp_result), 32'(e.res));
        chk("sb_flags", 32'(bus.rsp_flags), 32'(e.flg));
        chk("sb_flags_q", 32'(bus.flags_q), 32'(e.flg));
        rsp_cyc.push_back(cyc);
      end
      prev_vld = bus.rsp_valid;
      for (int i = 0; i < NR; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb_t n;
          logic [W-1:0] r;
          model(bus.req_op[3*i +: 3], bus.req_a[W*i +: W], bus.req_b[W*i +: W], r);
          n.id = i; n.res = r; n.flg = m_flags & FMASK; n.cyc = cyc;
          sbq.push_back(n);
          grant_log.push_back(i);
        end
      end
    end
  end

  task automatic drive(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_op[3*i +: 3] = op;
    bus.req_a[W*i +: W]  = a;
    bus.req_b[W*i +: W]  = b;
    bus.req_valid[i]     = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_accept(input int i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_valid[i] && bus.req_ready[i]) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) ok = 1'b1;
    end
    if (!ok) chk("rsp_timeout", 0, 1);
  endtask

  // One request on requester i, handshake and its response, rsp_ready held high
  task automatic run_one(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic [2:0] flg, output bit ok);
    bit ok_a;
    tick();
    drive(i, op, a, b);
    wait_accept(i, ok_a);
    tick();
    bus.req_valid[i] = 1'b0;
    wait_rsp(ok);
    ok  = ok & ok_a;
    res = bus.rsp_result;
    flg = bus.rsp_flags;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [2:0]   flg;   // {N,Z,C}
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit           ok;
    logic [W-1:0] res, held;
    logic [2:0]   flg;

    vecs[0]  = '{OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 3'b011};
    vecs[1]  = '{OP_ADD,   16'h1234, 16'h1111, 16'h2345, 3'b000};
    vecs[2]  = '{OP_SUB,   16'h0000, 16'h0001, 16'hFFFF, 3'b100};
    vecs[3]  = '{OP_SETC,  16'h0005, 16'h0007, 16'h0000, 3'b101};
    vecs[4]  = '{OP_AND,   16'h00F0, 16'h0F00, 16'h0000, 3'b011};
    vecs[5]  = '{OP_NOT,   16'h00FF, 16'h0000, 16'hFF00, 3'b101};
    vecs[6]  = '{OP_PASSA, 16'h8000, 16'h1234, 16'h8000, 3'b101};
    vecs[7]  = '{OP_PASSB, 16'h1234, 16'h0000, 16'h0000, 3'b011};
    vecs[8]  = '{OP_NONE,  16'h00F0, 16'h0F0F, 16'h0FFF, 3'b011};
    vecs[9]  = '{OP_ADD,   16'h7FFF, 16'h0001, 16'h8000, 3'b100};
    vecs[10] = '{OP_NOT,   16'hFFFF, 16'h0000, 16'h0000, 3'b010};

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset values with requests pending
    @(posedge clk);
    #2 bus.req_valid = '1;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 0);
    chk("rst_flags_q", 32'(bus.flags_q), 0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'(3'b111));
    chk("rst_alu_a", 32'(bus.alu_a), 0);
    chk("rst_alu_b", 32'(bus.alu_b), 0);
    do_reset();

    // Op table on requester 0
    for (int v = 0; v < 11; v++) begin
      run_one(0, vecs[v].op, vecs[v].a, vecs[v].b, res, flg, ok);
      if (ok) begin
        chk($sformatf("vec%0d_result", v), 32'(res), 32'(vecs[v].res));
        chk($sformatf("vec%0d_flags", v), 32'(flg), 32'(vecs[v].flg & FMASK));
      end
    end

    // Contention: grants alternate from requester 0, one response per 2 cycles
    do_reset();
    grant_log.delete();
    rsp_cyc.delete();
    tick();
    drive(0, OP_ADD, 16'h0101, 16'h0202);
    drive(1, OP_SUB, 16'h0505, 16'h0101);
    repeat (16) tick();
    bus.req_valid = '0;
    repeat (4) tick();
    chk("cont_grants", (grant_log.size() >= 6) ? 1 : 0, 1);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      chk($sformatf("cont_grant%0d", k), grant_log[k], k % 2);
    for (int k = 0; k < 4 && k + 1 < rsp_cyc.size(); k++)
      chk($sformatf("cont_gap%0d", k), rsp_cyc[k+1] - rsp_cyc[k], 2);

    // Backpressure: response held 5 cycles, pending request granted on release
    tick();
    drive(0, OP_ADD, 16'h4000, 16'h4000);
    wait_accept(0, ok);
    tick();
    bus.req_valid[0] = 1'b0;
    bus.rsp_ready    = 1'b0;
    drive(1, OP_PASSA, 16'hBEEF, 16'h0000);
    wait_rsp(ok);
    held = bus.rsp_result;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), 32'(bus.rsp_valid), 1);
      chk($sformatf("bp_result%0d", k), 32'(bus.rsp_result), 32'(held));
      chk($sformatf("bp_ready%0d", k), 32'(bus.req_ready), 0);
      chk($sformatf("bp_alu_op%0d", k), 32'(bus.alu_op), 32'(3'b111));
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #2 bus.rsp_ready = 1'b1;
    #1 chk("bp_release_grant", 32'(bus.req_ready), 32'(2'b10));
    tick();
    bus.req_valid = '0;
    repeat (5) tick();

    // Reset while in EXEC drops the op and restarts arbitration at requester 0
    run_one(1, OP_SETC, 16'h0000, 16'h0000, res, flg, ok);
    tick();
    drive(0, OP_ADD, 16'hFFFF, 16'h0001);
    wait_accept(0, ok);
    @(posedge clk);
    #2 bus.req_valid = '0;
    chk("rx_in_exec", 32'(bus.alu_op), 32'(OP_ADD));
    #2 rst = 1'b1;
    #1;
    chk("rx_alu_op", 32'(bus.alu_op), 32'(3'b111));
    chk("rx_alu_a", 32'(bus.alu_a), 0);
    chk("rx_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rx_flags_q", 32'(bus.flags_q), 0);
    chk("rx_req_ready", 32'(bus.req_ready), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rx_no_rsp%0d", k), 32'(bus.rsp_valid), 0);
    end
    tick();
    drive(0, OP_PASSB, 16'h0000, 16'h1357);
    drive(1, OP_PASSB, 16'h0000, 16'h2468);
    @(negedge clk);
    chk("rx_grant0", 32'(bus.req_ready), 32'(2'b01));
    tick();
    bus.req_valid = '0;
    repeat (6) tick();

    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
